// File: rtl/operand_entry.sv
// Operand entry: debounced enter key steps through A, B, opcode capture, then presents the operation.
// Latency: a clean press is captured DEBOUNCE_CYCLES+2 edges after KEY_n is first sampled low.
// Backpressure: PRESENT holds A/B/sub and valid until ready is seen high (clear aborts, reset discards).
module operand_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] SW,
    input  logic       KEY_n,
    input  logic       clear,
    input  logic       ready,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       sub,
    output logic       valid,
    output logic [1:0] step
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2) bits never wrap.
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A   = 2'd0,
        GET_B   = 2'd1,
        GET_OP  = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Synchronizer flops idle at 1 (key released, KEY_n is active-low).
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;

    // Debouncer state.
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Entry FSM and captured operation.
    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic             sub_q, sub_d;
    logic             valid_q, valid_d;

    logic             pressed_sync;
    logic             mismatch;
    logic             cnt_hit;
    logic             press_evt;

    // Two-flop synchronizer on the raw key.
    always_comb begin
        sync1_d = KEY_n;
        sync2_d = sync1_q;
    end

    // Debouncer: count consecutive disagreeing samples; any agreement restarts the count.
    always_comb begin
        pressed_sync = ~sync2_q;
        mismatch     = pressed_sync ^ db_q;
        cnt_hit      = mismatch && (cnt_q == CNT_LAST);
        db_d         = db_q;
        cnt_d        = cnt_q;
        if (!mismatch) begin
            cnt_d = '0;
        end else if (cnt_hit) begin
            db_d  = ~db_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Event fires on the same edge that the debounced level rises, so the
        // capture lands together with the pressed_db toggle.
        press_evt = cnt_hit && !db_q;
    end

    // Entry sequencing; clear overrides everything except reset and leaves the operands alone.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        if (clear) begin
            state_d = GET_A;
        end else begin
            case (state_q)
                GET_A: begin
                    if (press_evt) begin
                        a_d     = SW;
                        state_d = GET_B;
                    end
                end
                GET_B: begin
                    if (press_evt) begin
                        b_d     = SW;
                        state_d = GET_OP;
                    end
                end
                GET_OP: begin
                    if (press_evt) begin
                        sub_d   = SW[0];
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        state_d = GET_A;
                    end
                end
                default: begin
                    state_d = GET_A;
                end
            endcase
        end
        // valid is a flop that mirrors "next state is PRESENT", so it never
        // has a combinational path from ready.
        valid_d = (state_d == PRESENT);
    end

    // All state registers; reset wins over clear, ready and key events.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= GET_A;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            sub_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            valid_q <= valid_d;
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign sub   = sub_q;
    assign valid = valid_q;
    assign step  = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: table-driven full entries plus hand sequences for
// bounce, handshake, clear and reset corner cases.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_operand_entry;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] SW;
    logic       KEY_n;
    logic       clear;
    logic       ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       sub;
    logic       valid;
    logic [1:0] step;

    int n_total = 0;
    int n_pass  = 0;

    operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .SW    (SW),
        .KEY_n (KEY_n),
        .clear (clear),
        .ready (ready),
        .A     (A),
        .B     (B),
        .sub   (sub),
        .valid (valid),
        .step  (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sw_a;
        logic [3:0] sw_b;
        logic [3:0] sw_op;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       exp_sub;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Clean press: 6 edges low (capture on the 6th), then release and let it settle.
    task automatic press(input logic [3:0] sw);
        SW    = sw;
        KEY_n = 1'b0;
        repeat (6) tick();
        KEY_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        vecs[0] = '{sw_a: 4'h3, sw_b: 4'h5, sw_op: 4'h1, exp_a: 4'h3, exp_b: 4'h5, exp_sub: 1'b1};
        vecs[1] = '{sw_a: 4'hA, sw_b: 4'hF, sw_op: 4'hE, exp_a: 4'hA, exp_b: 4'hF, exp_sub: 1'b0};
        vecs[2] = '{sw_a: 4'h0, sw_b: 4'h0, sw_op: 4'hF, exp_a: 4'h0, exp_b: 4'h0, exp_sub: 1'b1};
        vecs[3] = '{sw_a: 4'hF, sw_b: 4'h1, sw_op: 4'h2, exp_a: 4'hF, exp_b: 4'h1, exp_sub: 1'b0};

        reset = 1'b1;
        SW    = 4'h0;
        KEY_n = 1'b1;
        clear = 1'b0;
        ready = 1'b0;
        repeat (2) tick();
        check("rst_A", A, 4'h0);
        check("rst_B", B, 4'h0);
        check("rst_sub", {3'b0, sub}, 4'h0);
        check("rst_valid", {3'b0, valid}, 4'h0);
        check("rst_step", {2'b0, step}, 4'h0);
        reset = 1'b0;
        repeat (2) tick();

        // Full entries, each held 20 cycles then accepted with a one-cycle ready.
        for (int i = 0; i < 4; i++) begin
            press(vecs[i].sw_a);
            check("tbl_step_after_a", {2'b0, step}, 4'h1);
            check("tbl_A", A, vecs[i].exp_a);
            press(vecs[i].sw_b);
            check("tbl_step_after_b", {2'b0, step}, 4'h2);
            check("tbl_B", B, vecs[i].exp_b);
            press(vecs[i].sw_op);
            repeat (20) tick();
            check("tbl_step_present", {2'b0, step}, 4'h3);
            check("tbl_valid", {3'b0, valid}, 4'h1);
            check("tbl_hold_A", A, vecs[i].exp_a);
            check("tbl_hold_B", B, vecs[i].exp_b);
            check("tbl_sub", {3'b0, sub}, {3'b0, vecs[i].exp_sub});
            ready = 1'b1;
            tick();
            ready = 1'b0;
            check("tbl_xfer_valid", {3'b0, valid}, 4'h0);
            check("tbl_xfer_step", {2'b0, step}, 4'h0);
        end

        // ready outside PRESENT is ignored; A keeps its last value.
        ready = 1'b1;
        repeat (3) tick();
        ready = 1'b0;
        check("ready_idle_step", {2'b0, step}, 4'h0);
        check("ready_idle_valid", {3'b0, valid}, 4'h0);
        check("retain_A", A, 4'hF);

        // Three-cycle glitch is shorter than the debounce window.
        SW    = 4'h9;
        KEY_n = 1'b0;
        repeat (3) tick();
        KEY_n = 1'b1;
        repeat (10) tick();
        check("glitch_step", {2'b0, step}, 4'h0);
        check("glitch_A", A, 4'hF);

        // Bounce: low 3, high 1, low 10 -> one capture on the 6th edge of the final low.
        SW    = 4'h7;
        KEY_n = 1'b0;
        repeat (3) tick();
        KEY_n = 1'b1;
        tick();
        KEY_n = 1'b0;
        repeat (5) tick();
        check("bounce_early_step", {2'b0, step}, 4'h0);
        tick();
        check("bounce_step", {2'b0, step}, 4'h1);
        check("bounce_A", A, 4'h7);
        repeat (4) tick();
        KEY_n = 1'b1;
        repeat (8) tick();
        check("bounce_single", {2'b0, step}, 4'h1);

        press(4'h2);
        press(4'h1);
        check("present_step", {2'b0, step}, 4'h3);

        // Presses while presenting change nothing.
        press(4'h9);
        check("pres_press_A", A, 4'h7);
        check("pres_press_B", B, 4'h2);
        check("pres_press_sub", {3'b0, sub}, 4'h1);
        check("pres_press_step", {2'b0, step}, 4'h3);
        check("pres_press_valid", {3'b0, valid}, 4'h1);

        // clear together with ready aborts instead of transferring.
        clear = 1'b1;
        ready = 1'b1;
        tick();
        clear = 1'b0;
        ready = 1'b0;
        check("clr_rdy_step", {2'b0, step}, 4'h0);
        check("clr_rdy_valid", {3'b0, valid}, 4'h0);
        check("clr_rdy_A", A, 4'h7);

        // clear on the same edge as the opcode press event discards it.
        press(4'h4);
        press(4'h6);
        check("getop_step", {2'b0, step}, 4'h2);
        SW    = 4'h0;
        KEY_n = 1'b0;
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_op_step", {2'b0, step}, 4'h0);
        check("clr_op_sub", {3'b0, sub}, 4'h1);
        check("clr_op_valid", {3'b0, valid}, 4'h0);
        repeat (10) tick();
        check("clr_held_noevt", {2'b0, step}, 4'h0);
        KEY_n = 1'b1;
        repeat (8) tick();

        // Reset in GET_B with the key held: one capture into A 6 edges after reset falls.
        press(4'h8);
        check("pre_rst_step", {2'b0, step}, 4'h1);
        SW    = 4'hC;
        KEY_n = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        check("rst2_A", A, 4'h0);
        check("rst2_B", B, 4'h0);
        check("rst2_sub", {3'b0, sub}, 4'h0);
        check("rst2_valid", {3'b0, valid}, 4'h0);
        check("rst2_step", {2'b0, step}, 4'h0);
        reset = 1'b0;
        repeat (5) tick();
        check("rst2_early_step", {2'b0, step}, 4'h0);
        tick();
        check("rst2_cap_step", {2'b0, step}, 4'h1);
        check("rst2_cap_A", A, 4'hC);
        KEY_n = 1'b1;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning: consecutive synchronized samples required to accept a key level change (legal range 2..65535).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 SW  input  4  operand/opcode switches, asynchronous to clk.
REQ-005 KEY_n  input  1  raw enter pushbutton, active-low, bouncing, asynchronous.
REQ-006 clear  input  1  synchronous abort; discards partial entry.
REQ-007 ready  input  1  downstream add/sub stage accepts the presented operands.
REQ-008 A  output  4  captured operand A.
REQ-009 B  output  4  captured operand B.
REQ-010 sub  output  1  captured opcode; 0 = add, 1 = subtract.
REQ-011 valid  output  1  A, B and sub form a complete, stable operation.
REQ-012 step  output  2  current state code for LED display.

Function
REQ-013 KEY_n passes through a 2-flop synchronizer; the synchronized pressed level is the inverse of the second flop.
REQ-014 The debouncer holds a registered pressed_db level and a counter; while the synchronized level differs from pressed_db, the counter increments each cycle; when they match, the counter clears to 0.
REQ-015 pressed_db toggles, and the counter clears, on the edge at which the counter has reached DEBOUNCE_CYCLES-1 with a mismatch still present; one bounce resets the count.
REQ-016 press_evt is asserted for exactly one cycle per 0->1 transition of pressed_db; releases generate no event.
REQ-017 With KEY_n held low from a clean idle state, the capture caused by the press is visible on outputs exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling KEY_n low.
REQ-018 FSM states and step codes: GET_A=0, GET_B=1, GET_OP=2, PRESENT=3.
REQ-019 GET_A: on press_evt, A <= SW, go to GET_B.
REQ-020 GET_B: on press_evt, B <= SW, go to GET_OP.
REQ-021 GET_OP: on press_evt, sub <= SW[0], go to PRESENT; SW[3:1] ignored.
REQ-022 PRESENT: valid = 1; A, B, sub held constant; press_evt ignored.
REQ-023 PRESENT with ready = 1 on an edge: transfer completes; next state GET_A; valid low from the following cycle.
REQ-024 ready is ignored in all states except PRESENT; valid is registered and never depends combinationally on ready.
REQ-025 A and B retain their last captured values in GET_A/GET_B/GET_OP until overwritten; only valid qualifies them.
REQ-026 clear = 1 in any state: next state GET_A, valid low next cycle; A, B, sub unchanged; a press_evt on the same edge is discarded.
REQ-027 clear and ready both high in PRESENT: treated as clear; the transfer does not count as accepted.
REQ-028 clear does not affect the synchronizer or debouncer; a key still held after clear produces no new event until released and re-pressed.
REQ-029 Debouncer counter width is sufficient for DEBOUNCE_CYCLES with no wrap-around.

Reset
REQ-030 reset = 1 on an edge: state GET_A, A = 4'h0, B = 4'h0, sub = 0, valid = 0, step = 0, counter = 0, pressed_db = 0, synchronizer flops = 1 (released).
REQ-031 reset takes priority over clear, ready and press_evt; reset mid-entry or in PRESENT discards the operation without a transfer.
REQ-032 A key held across reset deassertion is debounced from the released state and produces one press_evt DEBOUNCE_CYCLES+2 edges after reset falls.

Verification
REQ-033 Clean entry, DEBOUNCE_CYCLES=4: SW=4'h3 press, SW=4'h5 press, SW=4'h1 press, ready held 0 -> valid=1, A=3, B=5, sub=1, step=3, stable for 20 cycles.
REQ-034 Bounce: KEY_n low 3 cycles, high 1, low 10 -> exactly one capture, 6 edges after the final low onset; glitch under 4 cycles -> no capture.
REQ-035 Handshake: in PRESENT, ready=1 one cycle -> valid=0 next cycle, step=0; further ready pulses ignored; new press captures A.
REQ-036 Presses in PRESENT with ready=0 -> A/B/sub unchanged, state stays PRESENT.
REQ-037 clear in GET_OP with simultaneous press_evt -> step=0, sub unchanged, valid=0; clear+ready in PRESENT -> step=0, no transfer.
REQ-038 reset asserted in GET_B with key held -> all outputs at REQ-030 values; one capture into A 6 edges after reset falls.
